// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: holds one captured lane pair (A older, B younger), merges load
// responses in order and retires both lanes into the two register-file write ports.
module wb_retire_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            me_adv,
  input  logic            me_validA,
  input  logic            me_validB,
  input  logic [4:0]      me_rdA,
  input  logic [4:0]      me_rdB,
  input  logic            me_wtenA,
  input  logic            me_wtenB,
  input  logic [XLEN-1:0] me_fwdA,
  input  logic [XLEN-1:0] me_fwdB,
  input  logic            me_loadA,
  input  logic            me_loadB,
  input  logic [2:0]      me_lsuA,
  input  logic [2:0]      me_lsuB,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we0,
  output logic [4:0]      rf_wa0,
  output logic [XLEN-1:0] rf_wd0,
  output logic            rf_we1,
  output logic [4:0]      rf_wa1,
  output logic [XLEN-1:0] rf_wd1,
  output logic            s_wb1_stall_D,
  output logic            s_wb2_stall_D,
  output logic [1:0]      wb_retire,
  output logic [63:0]     wb_instret
);

  typedef enum logic [1:0] {L_EMPTY, L_WAIT, L_READY, L_DONE} lane_st_t;

  lane_st_t        st_a_p0, st_b_p0, st_a_nx, st_b_nx;
  logic [4:0]      rd_a_p0, rd_b_p0;
  logic            wten_a_p0, wten_b_p0;
  logic [2:0]      lsu_a_p0, lsu_b_p0;
  logic [1:0]      off_a_p0, off_b_p0;
  logic [XLEN-1:0] data_a_p0, data_b_p0;

  logic pend_a, pend_b, valid_a, valid_b, done_a, done_b;
  logic ret_a, ret_b, stall, same_rd;

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] lsu,
                                                   input logic [1:0] off,
                                                   input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (lsu)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Retire decision: a response always goes to the oldest pending load
  always_comb begin
    pend_a  = (st_a_p0 == L_WAIT);
    pend_b  = (st_b_p0 == L_WAIT);
    valid_a = (st_a_p0 != L_EMPTY);
    valid_b = (st_b_p0 != L_EMPTY);
    done_a  = (st_a_p0 == L_DONE);
    done_b  = (st_b_p0 == L_DONE);
    ret_a   = (st_a_p0 == L_READY) | (pend_a & dmem_rvalid);
    ret_b   = ((st_b_p0 == L_READY) | (pend_b & dmem_rvalid & ~pend_a))
              & (ret_a | done_a | ~valid_a);
    stall   = (valid_a & ~done_a & ~ret_a) | (valid_b & ~done_b & ~ret_b);
    same_rd = ret_a & ret_b & wten_a_p0 & wten_b_p0 & (rd_a_p0 == rd_b_p0);

    rf_we0 = ret_a & wten_a_p0 & ~same_rd;
    rf_wa0 = ret_a ? rd_a_p0 : 5'd0;
    rf_wd0 = '0;
    if (ret_a) rf_wd0 = pend_a ? load_extract(lsu_a_p0, off_a_p0, dmem_rdata) : data_a_p0;
    rf_we1 = ret_b & wten_b_p0;
    rf_wa1 = ret_b ? rd_b_p0 : 5'd0;
    rf_wd1 = '0;
    if (ret_b) rf_wd1 = pend_b ? load_extract(lsu_b_p0, off_b_p0, dmem_rdata) : data_b_p0;

    s_wb1_stall_D = stall;
    s_wb2_stall_D = stall;
    wb_retire     = {1'b0, ret_a} + {1'b0, ret_b};
  end

  always_comb begin
    st_a_nx = st_a_p0;
    st_b_nx = st_b_p0;
    if (!stall) begin
      st_a_nx = (me_adv & me_validA) ? (me_loadA ? L_WAIT : L_READY) : L_EMPTY;
      st_b_nx = (me_adv & me_validB) ? (me_loadB ? L_WAIT : L_READY) : L_EMPTY;
    end else begin
      if (ret_a) st_a_nx = L_DONE;
      if (ret_b) st_b_nx = L_DONE;
    end
  end

  // Stage p0: captured pair
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_a_p0    <= L_EMPTY;
      st_b_p0    <= L_EMPTY;
      wb_instret <= 64'd0;
    end else begin
      st_a_p0    <= st_a_nx;
      st_b_p0    <= st_b_nx;
      wb_instret <= wb_instret + {62'd0, wb_retire};
    end
  end

  always_ff @(posedge CLK) begin
    if (!stall) begin
      rd_a_p0   <= me_rdA;
      rd_b_p0   <= me_rdB;
      wten_a_p0 <= me_wtenA;
      wten_b_p0 <= me_wtenB;
      lsu_a_p0  <= me_lsuA;
      lsu_b_p0  <= me_lsuB;
      off_a_p0  <= me_fwdA[1:0];
      off_b_p0  <= me_fwdB[1:0];
      data_a_p0 <= me_fwdA;
      data_b_p0 <= me_fwdB;
    end
  end

endmodule

// File: tb/tb_wb_retire_unit.sv
// Bench for wb_retire_unit: directed scenarios plus random traffic against a
// program-order retire-queue reference model.
module tb_wb_retire_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        me_adv, me_validA, me_validB, me_wtenA, me_wtenB, me_loadA, me_loadB;
  logic [4:0]  me_rdA, me_rdB;
  logic [31:0] me_fwdA, me_fwdB;
  logic [2:0]  me_lsuA, me_lsuB;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we0, rf_we1, s_wb1_stall_D, s_wb2_stall_D;
  logic [4:0]  rf_wa0, rf_wa1;
  logic [31:0] rf_wd0, rf_wd1;
  logic [1:0]  wb_retire;
  logic [63:0] wb_instret;

  wb_retire_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .me_adv(me_adv),
    .me_validA(me_validA), .me_validB(me_validB),
    .me_rdA(me_rdA), .me_rdB(me_rdB),
    .me_wtenA(me_wtenA), .me_wtenB(me_wtenB),
    .me_fwdA(me_fwdA), .me_fwdB(me_fwdB),
    .me_loadA(me_loadA), .me_loadB(me_loadB),
    .me_lsuA(me_lsuA), .me_lsuB(me_lsuB),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we0(rf_we0), .rf_wa0(rf_wa0), .rf_wd0(rf_wd0),
    .rf_we1(rf_we1), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
    .s_wb1_stall_D(s_wb1_stall_D), .s_wb2_stall_D(s_wb2_stall_D),
    .wb_retire(wb_retire), .wb_instret(wb_instret)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: unretired instructions of the current pair, oldest first
  typedef struct {
    bit        lane;
    bit [4:0]  rd;
    bit        wten;
    bit        load;
    bit [2:0]  lsu;
    bit [31:0] fwd;
  } ins_t;

  ins_t      q[$];
  bit [63:0] m_instret = 64'd0;

  function automatic bit [31:0] ref_load(input bit [2:0] lsu, input bit [31:0] addr,
                                         input bit [31:0] w);
    int unsigned off;
    bit [31:0]   b, h;
    off = addr % 4;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (lsu)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic drive(input bit adv,
                       input bit va, input bit [4:0] ra, input bit [31:0] fa,
                       input bit la, input bit [2:0] sa,
                       input bit vb, input bit [4:0] rb, input bit [31:0] fb,
                       input bit lb, input bit [2:0] sb,
                       input bit rv, input bit [31:0] rdat);
    me_adv = adv;
    me_validA = va; me_rdA = ra; me_wtenA = (ra != 0); me_fwdA = fa; me_loadA = la; me_lsuA = sa;
    me_validB = vb; me_rdB = rb; me_wtenB = (rb != 0); me_fwdB = fb; me_loadB = lb; me_lsuB = sb;
    dmem_rvalid = rv; dmem_rdata = rdat;
  endtask

  task automatic idle(input bit rv, input bit [31:0] rdat);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rv, rdat);
  endtask

  // Compare one cycle against the model, advance the model, move to the next cycle
  task automatic step();
    bit        we[2];
    bit [4:0]  wa[2];
    bit [31:0] wd[2];
    int        n;
    bit        used;
    bit        stall;
    ins_t      h;
    ins_t      ni;
    #1;
    we[0] = 0; we[1] = 0; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    n = 0; used = 0;
    while (q.size() > 0) begin
      h = q[0];
      if (h.load) begin
        if (!dmem_rvalid || used) break;
        used = 1;
        wd[h.lane] = ref_load(h.lsu, h.fwd, dmem_rdata);
      end else begin
        wd[h.lane] = h.fwd;
      end
      we[h.lane] = h.wten;
      wa[h.lane] = h.rd;
      n++;
      void'(q.pop_front());
    end
    if (n == 2 && we[0] && we[1] && wa[0] == wa[1]) we[0] = 0;
    stall = (q.size() > 0);

    chk("rf_we0", rf_we0, we[0]);
    chk("rf_wa0", rf_wa0, wa[0]);
    chk("rf_wd0", rf_wd0, wd[0]);
    chk("rf_we1", rf_we1, we[1]);
    chk("rf_wa1", rf_wa1, wa[1]);
    chk("rf_wd1", rf_wd1, wd[1]);
    chk("stall1", s_wb1_stall_D, stall);
    chk("stall2", s_wb2_stall_D, stall);
    chk("wb_retire", wb_retire, n);
    chk("wb_instret", wb_instret, m_instret);

    if (RST) begin
      q.delete();
      m_instret = 0;
    end else begin
      m_instret += n;
      if (!stall && me_adv) begin
        if (me_validA) begin
          ni.lane = 0; ni.rd = me_rdA; ni.wten = me_wtenA; ni.load = me_loadA;
          ni.lsu = me_lsuA; ni.fwd = me_fwdA;
          q.push_back(ni);
        end
        if (me_validB) begin
          ni.lane = 1; ni.rd = me_rdB; ni.wten = me_wtenB; ni.load = me_loadB;
          ni.lsu = me_lsuB; ni.fwd = me_fwdB;
          q.push_back(ni);
        end
      end
    end
    @(negedge CLK);
  endtask

  bit [2:0] lsu_tab[5];

  initial begin
    lsu_tab[0] = 3'd0; lsu_tab[1] = 3'd1; lsu_tab[2] = 3'd2;
    lsu_tab[3] = 3'd4; lsu_tab[4] = 3'd5;

    RST = 1;
    idle(0, 0);
    @(negedge CLK);
    step();
    step();
    RST = 0;

    // Two ALU ops
    drive(1, 1, 5, 32'h11, 0, 0, 1, 6, 32'h22, 0, 0, 0, 0); step();
    idle(0, 0); #1;
    chk("alu_pair_retire", wb_retire, 2);
    chk("alu_pair_wd0", rf_wd0, 32'h11);
    step();

    // Same destination: younger wins
    drive(1, 1, 7, 32'hAA, 0, 0, 1, 7, 32'hBB, 0, 0, 0, 0); step();
    idle(0, 0); #1;
    chk("same_rd_we0", rf_we0, 0);
    chk("same_rd_wd1", rf_wd1, 32'hBB);
    step();

    // A = LB offset 3, B = ALU, response three cycles later
    drive(1, 1, 8, 32'h1003, 1, 3'd0, 1, 9, 32'h99, 0, 0, 0, 0); step();
    idle(0, 0); step(); step();
    idle(0, 0); #1;
    chk("lb_wait_stall", s_wb1_stall_D, 1);
    step();
    idle(1, 32'h80FF_0000); #1;
    chk("lb_wd0", rf_wd0, 32'hFFFF_FF80);
    step();

    // A = ALU, B = LHU offset 2
    drive(1, 1, 10, 32'h55, 0, 0, 1, 11, 32'h2002, 1, 3'd5, 0, 0); step();
    idle(0, 0); #1;
    chk("lhu_a_alone", wb_retire, 1);
    step();
    idle(1, 32'hBEEF_1234); #1;
    chk("lhu_wd1", rf_wd1, 32'h0000_BEEF);
    step();

    // Both loads, back-to-back responses, then a stray response
    drive(1, 1, 12, 32'h3000, 1, 3'd2, 1, 13, 32'h3001, 1, 3'd4, 0, 0); step();
    idle(1, 32'hDEAD_BEEF); step();
    idle(1, 32'h0000_5A00); #1;
    chk("lbu_wd1", rf_wd1, 32'h0000_005A);
    step();
    idle(1, 32'h1234_5678); step();

    // Reset while a load is pending; later response must be dropped
    drive(1, 1, 14, 32'h4000, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0); step();
    RST = 1; idle(0, 0); step();
    RST = 0; idle(1, 32'hCAFE_F00D); #1;
    chk("rst_instret", wb_instret, 0);
    step();
    idle(0, 0); step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, lsu_tab[$urandom_range(0, 4)],
            $urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, lsu_tab[$urandom_range(0, 4)],
            $urandom_range(0, 1) == 1, $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
